fixed_exp_neg_pipe: RTL and testbench

Streaming fixed-point evaluator of e^(-x) for unsigned x, feeding softmax/normalisation datapaths in the scalar_operators family.
- Splits x into integer part I and fractional part.
- Looks up e^(-k/8) via the existing fractional_lut_16 and right-shifts the result by I.
- Two-stage valid/ready pipeline; throughput one result per cycle.

---
 rtl/fixed_exp_pkg.sv | 19 +
 rtl/fractional_lut_16.sv | 31 +++
 rtl/fixed_exp_neg_pipe.sv | 123 ++++++++++++
 tb/tb_fixed_exp_neg_pipe.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/fixed_exp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fixed_exp_pkg
//  Description : Shared constants and types for the e^(-x) pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
package fixed_exp_pkg;

    localparam int EXP_LUT_ADDR_WIDTH = 3;
    localparam int EXP_OUT_WIDTH      = 17;
    localparam logic [16:0] EXP_OUT_ONE = 17'd65536;
    localparam int EXP_MAX_SHIFT      = 16;
    // Bits needed to hold any in-range shift amount (0..EXP_MAX_SHIFT).
    localparam int EXP_SHIFT_WIDTH    = $clog2(EXP_MAX_SHIFT + 1);

    typedef logic [16:0] exp_q1_16_t;

endpackage
`default_nettype wire

// File: rtl/fractional_lut_16.sv
`default_nettype none
// ============================================================================
//  Module      : fractional_lut_16
//  Description : Combinational table of e^(-k/8) in Q1.16, k = 0..7.
//  Revision    : 1.0 - initial release
// ============================================================================
module fractional_lut_16
    import fixed_exp_pkg::*;
(
    input  logic [EXP_LUT_ADDR_WIDTH-1:0] i_addr,
    output exp_q1_16_t                    o_data
);

    // round(65536 * e^(-k/8))
    always_comb begin
        o_data = EXP_OUT_ONE;
        case (i_addr)
            3'd0:    o_data = EXP_OUT_ONE;
            3'd1:    o_data = 17'd57835;
            3'd2:    o_data = 17'd51039;
            3'd3:    o_data = 17'd45042;
            3'd4:    o_data = 17'd39750;
            3'd5:    o_data = 17'd35079;
            3'd6:    o_data = 17'd30957;
            3'd7:    o_data = 17'd27319;
            default: o_data = EXP_OUT_ONE;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/fixed_exp_neg_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : fixed_exp_neg_pipe
//  Description : Two-stage valid/ready pipeline computing e^(-x) in Q1.16
//                as LUT[frac] >> int. Define FIXED_EXP_ROUND_EN to round the
//                shift to nearest instead of truncating.
//  Revision    : 1.0 - initial release
// ============================================================================
module fixed_exp_neg_pipe
    import fixed_exp_pkg::*;
#(
    parameter int DATA_IN_WIDTH      = 8,
    parameter int DATA_IN_FRAC_WIDTH = 3,
    parameter int DATA_OUT_WIDTH     = 17
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DATA_IN_WIDTH-1:0]  data_in_0,
    input  logic                      data_in_0_valid,
    output logic                      data_in_0_ready,
    output logic [DATA_OUT_WIDTH-1:0] data_out_0,
    output logic                      data_out_0_valid,
    input  logic                      data_out_0_ready
);

    localparam int c_int_width = DATA_IN_WIDTH - DATA_IN_FRAC_WIDTH;
    localparam logic [EXP_SHIFT_WIDTH-1:0] c_max_shift = EXP_SHIFT_WIDTH'(EXP_MAX_SHIFT);

    if (DATA_OUT_WIDTH != EXP_OUT_WIDTH) begin : g_chk_out_width
        $error("fixed_exp_neg_pipe: DATA_OUT_WIDTH must be 17");
    end
    if (DATA_IN_FRAC_WIDTH < EXP_LUT_ADDR_WIDTH) begin : g_chk_frac_width
        $error("fixed_exp_neg_pipe: DATA_IN_FRAC_WIDTH must be >= 3");
    end
    if (DATA_IN_WIDTH <= DATA_IN_FRAC_WIDTH) begin : g_chk_in_width
        $error("fixed_exp_neg_pipe: DATA_IN_WIDTH must exceed DATA_IN_FRAC_WIDTH");
    end

    logic                          r_s1_valid;
    exp_q1_16_t                    r_s1_lut;
    logic [c_int_width-1:0]        r_s1_shift;
    logic                          r_out_valid;
    exp_q1_16_t                    r_out_data;

    logic [c_int_width-1:0]        w_int_part;
    logic [EXP_LUT_ADDR_WIDTH-1:0] w_frac_idx;
    exp_q1_16_t                    w_lut_data;
    logic                          w_s1_adv;
    logic                          w_s2_adv;
    logic                          w_accept;
    logic [EXP_SHIFT_WIDTH-1:0]    w_shift_amt;
    logic                          w_shift_ovf;
    exp_q1_16_t                    w_round_inc;
    exp_q1_16_t                    w_sum;
    exp_q1_16_t                    w_stage2_result;

    // Fraction bits below the top three are dropped (floor).
    assign w_int_part = data_in_0[DATA_IN_WIDTH-1:DATA_IN_FRAC_WIDTH];
    assign w_frac_idx = data_in_0[DATA_IN_FRAC_WIDTH-1 -: EXP_LUT_ADDR_WIDTH];

    fractional_lut_16 u_lut (
        .i_addr (w_frac_idx),
        .o_data (w_lut_data)
    );

    // Ready chain is combinational from downstream ready only, never from valid.
    assign w_s2_adv        = !r_out_valid || data_out_0_ready;
    assign w_s1_adv        = !r_s1_valid || w_s2_adv;
    assign data_in_0_ready = w_s1_adv && rst_n;
    assign w_accept        = data_in_0_valid && data_in_0_ready;

    if (c_int_width > EXP_SHIFT_WIDTH) begin : g_shift_wide
        assign w_shift_amt = r_s1_shift[EXP_SHIFT_WIDTH-1:0];
        assign w_shift_ovf = (|r_s1_shift[c_int_width-1:EXP_SHIFT_WIDTH])
                           || (r_s1_shift[EXP_SHIFT_WIDTH-1:0] > c_max_shift);
    end else if (c_int_width == EXP_SHIFT_WIDTH) begin : g_shift_exact
        assign w_shift_amt = r_s1_shift;
        assign w_shift_ovf = (r_s1_shift > c_max_shift);
    end else begin : g_shift_narrow
        assign w_shift_amt = EXP_SHIFT_WIDTH'(r_s1_shift);
        assign w_shift_ovf = 1'b0;
    end

`ifdef FIXED_EXP_ROUND_EN
    // Half-LSB bias; the sum stays within 17 bits since LUT <= 1.0 and shift >= 1.
    assign w_round_inc = (w_shift_amt == '0) ? '0
                       : (exp_q1_16_t'(1) << (w_shift_amt - 1'b1));
`else
    assign w_round_inc = '0;
`endif

    assign w_sum           = r_s1_lut + w_round_inc;
    assign w_stage2_result = w_shift_ovf ? '0 : (w_sum >> w_shift_amt);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_lut    <= '0;
            r_s1_shift  <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (w_s1_adv) begin
                r_s1_valid <= w_accept;
            end
            if (w_accept) begin
                r_s1_lut   <= w_lut_data;
                r_s1_shift <= w_int_part;
            end
            if (w_s2_adv) begin
                r_out_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_out_data <= w_stage2_result;
                end
            end
        end
    end

    assign data_out_0       = r_out_data;
    assign data_out_0_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_fixed_exp_neg_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fixed_exp_neg_pipe
//  Description : Directed scoreboard bench for fixed_exp_neg_pipe.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fixed_exp_neg_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  data_in_0;
    logic        data_in_0_valid;
    logic        data_in_0_ready;
    logic [16:0] data_out_0;
    logic        data_out_0_valid;
    logic        data_out_0_ready;

    always #5 clk = ~clk;

    fixed_exp_neg_pipe #(
        .DATA_IN_WIDTH      (8),
        .DATA_IN_FRAC_WIDTH (3),
        .DATA_OUT_WIDTH     (17)
    ) u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .data_in_0        (data_in_0),
        .data_in_0_valid  (data_in_0_valid),
        .data_in_0_ready  (data_in_0_ready),
        .data_out_0       (data_out_0),
        .data_out_0_valid (data_out_0_valid),
        .data_out_0_ready (data_out_0_ready)
    );

`ifdef FIXED_EXP_ROUND_EN
    localparam logic [16:0] c_exp_1p125 = 17'd28918;
    localparam logic [16:0] c_exp_2p875 = 17'd6830;
`else
    localparam logic [16:0] c_exp_1p125 = 17'd28917;
    localparam logic [16:0] c_exp_2p875 = 17'd6829;
`endif

    typedef struct {
        logic [16:0] val;
        int          acc_cyc;
    } item_t;

    item_t       sb_q[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    bit          lat_check;
    bit          last_acc;
    bit          prev_stall;
    logic [16:0] prev_data;
    logic [16:0] cur_exp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    function automatic logic [16:0] lut_val(input int k);
        case (k)
            0: return 17'd65536;
            1: return 17'd57835;
            2: return 17'd51039;
            3: return 17'd45042;
            4: return 17'd39750;
            5: return 17'd35079;
            6: return 17'd30957;
            default: return 17'd27319;
        endcase
    endfunction

    function automatic logic [16:0] model(input logic [7:0] x);
        int          ip = int'(x[7:3]);
        logic [31:0] v  = 32'(lut_val(int'(x[2:0])));
        if (ip > 16) return 17'd0;
`ifdef FIXED_EXP_ROUND_EN
        if (ip > 0) v = v + (32'd1 << (ip - 1));
`endif
        return 17'(v >> ip);
    endfunction

    // One clock: inputs are set at the preceding negedge, sampled here, then the edge.
    task automatic cycle();
        item_t it;
        #1;
        last_acc = 1'b0;
        if (rst_n) begin
            check("in_ready", data_in_0_ready,
                  !(sb_q.size() == 2 && data_out_0_valid && !data_out_0_ready));
            if (prev_stall) begin
                check("hold_valid", data_out_0_valid, 1);
                check("hold_data", data_out_0, prev_data);
            end
            if (data_out_0_valid) begin
                if (sb_q.size() == 0) begin
                    check("spurious_valid", data_out_0_valid, 0);
                end else if (data_out_0_ready) begin
                    it = sb_q.pop_front();
                    check("data", data_out_0, it.val);
                    if (lat_check) check("latency", cyc - it.acc_cyc, 2);
                end
            end
            if (data_in_0_valid && data_in_0_ready) begin
                last_acc = 1'b1;
                sb_q.push_back('{val: cur_exp, acc_cyc: cyc});
            end
            prev_stall = data_out_0_valid && !data_out_0_ready;
            prev_data  = data_out_0;
        end else begin
            check("rst_in_ready", data_in_0_ready, 0);
            prev_stall = 1'b0;
        end
        @(posedge clk);
        cyc++;
        if (!rst_n) sb_q.delete();
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] x, input logic [16:0] e);
        data_in_0       = x;
        data_in_0_valid = 1'b1;
        cur_exp         = e;
        for (int n = 0; n < 20; n++) begin
            cycle();
            if (last_acc) break;
        end
        if (!last_acc) check("accept_timeout", last_acc, 1);
        data_in_0_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 20 && sb_q.size() > 0; n++) cycle();
        check("drain_empty", sb_q.size(), 0);
    endtask

    logic [7:0] xs [8] = '{8'h00, 8'h09, 8'h17, 8'h80, 8'h88, 8'hFF, 8'h23, 8'h41};

    initial begin
        int idx;
        rst_n            = 1'b0;
        data_in_0        = '0;
        data_in_0_valid  = 1'b0;
        data_out_0_ready = 1'b1;
        lat_check        = 1'b1;
        prev_stall       = 1'b0;
        prev_data        = '0;
        cur_exp          = '0;
        @(negedge clk);

        // Reset state
        for (int n = 0; n < 3; n++) begin
            check("rst_out_valid", data_out_0_valid, 0);
            check("rst_out_data", data_out_0, 0);
            cycle();
        end
        rst_n = 1'b1;
        cycle();

        // Isolated items: value and two-cycle latency
        send(8'b00000_000, 17'd65536);     drain();
        send(8'b00001_001, c_exp_1p125);   drain();
        send(8'b00010_111, c_exp_2p875);   drain();
        send(8'b10000_000, 17'd1);         drain();
        send(8'b10001_000, 17'd0);         drain();
        send(8'hFF,        17'd0);         drain();

        // Back-to-back stream with downstream stall on cycles 3-5
        lat_check = 1'b0;
        idx = 0;
        for (int c = 0; c < 40 && (idx < 8 || sb_q.size() > 0); c++) begin
            data_out_0_ready = !(c >= 3 && c <= 5);
            if (idx < 8) begin
                data_in_0       = xs[idx];
                data_in_0_valid = 1'b1;
                cur_exp         = model(xs[idx]);
            end else begin
                data_in_0_valid = 1'b0;
            end
            cycle();
            if (last_acc) idx++;
        end
        data_in_0_valid  = 1'b0;
        data_out_0_ready = 1'b1;
        check("stream_sent", idx, 8);
        check("stream_empty", sb_q.size(), 0);

        // Reset with two items in flight
        data_out_0_ready = 1'b0;
        send(8'h09, model(8'h09));
        send(8'h17, model(8'h17));
        check("full_out_valid", data_out_0_valid, 1);
        rst_n = 1'b0;
        cycle();
        rst_n            = 1'b1;
        data_out_0_ready = 1'b1;
        check("post_rst_out_valid", data_out_0_valid, 0);
        cycle();
        check("post_rst_s1_flush", data_out_0_valid, 0);
        cycle();
        lat_check = 1'b1;
        send(8'h00, 17'd65536);
        drain();
        for (int n = 0; n < 3; n++) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
